// File: rtl/add_arbiter.sv
// Round-robin arbiter that time-shares one signed adder between NUM_REQ clients.
// One request in flight: IDLE grants, ADD computes, RESP holds until consumed.
module add_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int WIDTH   = 16,
    parameter  int SUM_W   = WIDTH + 2,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [SUM_W-1:0]         rsp_sum,
    output logic                     busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [ID_W-1:0]          rr_ptr_q, rr_ptr_d;
    logic signed [WIDTH-1:0]  a_q, a_d;
    logic signed [WIDTH-1:0]  b_q, b_d;
    logic [ID_W-1:0]          id_q, id_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]          rsp_id_q, rsp_id_d;
    logic signed [SUM_W-1:0]  rsp_sum_q, rsp_sum_d;

    logic                     win_found;
    logic [ID_W-1:0]          win_id;
    logic [ID_W-1:0]          idx_w;
    int                       idx;
    logic signed [SUM_W-1:0]  a_ext, b_ext;

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        idx_w     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx   = (int'(rr_ptr_q) + i) % NUM_REQ;
            idx_w = ID_W'(idx);
            if (!win_found && req_valid[idx_w]) begin
                win_found = 1'b1;
                win_id    = idx_w;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (!rst_b && state_q == IDLE && win_found) begin
            req_ready[win_id] = 1'b1;
        end
    end

    assign a_ext = {{(SUM_W-WIDTH){a_q[WIDTH-1]}}, a_q};
    assign b_ext = {{(SUM_W-WIDTH){b_q[WIDTH-1]}}, b_q};

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    a_d      = req_a[win_id*WIDTH +: WIDTH];
                    b_d      = req_b[win_id*WIDTH +: WIDTH];
                    id_d     = win_id;
                    rr_ptr_d = (win_id == ID_W'(NUM_REQ - 1)) ?
                               '0 : win_id + 1'b1;
                    state_d  = ADD;
                end
            end
            ADD: begin
                rsp_sum_d   = a_ext + b_ext;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_add_arbiter.sv
// Randomized scoreboard bench for add_arbiter: stimulus pushes expected
// responses, an independent monitor pops and compares them.
module tb_add_arbiter;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int SW = W + 2;

    logic            clk = 1'b0;
    logic            rst_b;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*W-1:0]  req_a;
    logic [N*W-1:0]  req_b;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [1:0]      rsp_id;
    logic [SW-1:0]   rsp_sum;
    logic            busy;

    add_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state: pointer as a plain integer, expected responses queued.
    int     rr_m = 0;
    int     q_id[$];
    longint q_sum[$];
    int     oa[N];
    int     ob[N];
    int     rdy_mode = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: rsp_ready = 1'b1;
                1: rsp_ready = 1'($urandom % 2);
                2: rsp_ready = 1'b0;
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst_b && rsp_valid) begin
            if (q_id.size() == 0) begin
                chk("rsp_unexpected", 1, 0);
            end else begin
                chk("rsp_id", longint'(rsp_id), longint'(q_id[0]));
                chk("rsp_sum", longint'($signed(rsp_sum)), q_sum[0]);
                if (rsp_ready) begin
                    void'(q_id.pop_front());
                    void'(q_sum.pop_front());
                end
            end
        end
    end

    task automatic drive_ops();
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = W'(oa[i]);
            req_b[i*W +: W] = W'(ob[i]);
        end
    endtask

    task automatic junk_ops();
        req_a = {$urandom, $urandom};
        req_b = {$urandom, $urandom};
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 1, 0);
    endtask

    task automatic apply_reset(input int cycles);
        rst_b = 1'b1;
        q_id.delete();
        q_sum.delete();
        rr_m = 0;
        for (int c = 0; c < cycles; c++) begin
            req_valid = N'($urandom);
            junk_ops();
            @(negedge clk);
            #1;
            chk("rst_req_ready", longint'(req_ready), 0);
            chk("rst_rsp_valid", longint'(rsp_valid), 0);
            chk("rst_rsp_sum", longint'(rsp_sum), 0);
            chk("rst_busy", longint'(busy), 0);
        end
        req_valid = '0;
        rst_b = 1'b0;
    endtask

    // Present mask with oa/ob for one cycle; model predicts the grant.
    task automatic issue(input logic [N-1:0] mask, output int got);
        int w;
        logic [N-1:0] exp_rdy;
        wait_idle();
        req_valid = mask;
        drive_ops();
        #1;
        w = -1;
        for (int k = 0; k < N; k++) begin
            if (w < 0 && mask[(rr_m + k) % N]) w = (rr_m + k) % N;
        end
        exp_rdy = '0;
        if (w >= 0) begin
            exp_rdy[w] = 1'b1;
            q_id.push_back(w);
            q_sum.push_back(longint'(oa[w]) + longint'(ob[w]));
            rr_m = (w + 1) % N;
        end
        chk("req_ready", longint'(req_ready), longint'(exp_rdy));
        got = -1;
        for (int k = 0; k < N; k++) if (req_ready[k]) got = k;
        @(posedge clk);
        #1;
        req_valid = '0;
        junk_ops();
    endtask

    task automatic set_all(input int a, input int b);
        for (int i = 0; i < N; i++) begin
            oa[i] = a;
            ob[i] = b;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q_id.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", longint'(q_id.size()), 0);
    endtask

    initial begin
        int got;
        int mask;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        rst_b = 1'b1;

        // T1 reset with random inputs
        apply_reset(3);

        // T2 single request, latency
        set_all(0, 0);
        oa[0] = 7641;
        ob[0] = 4611;
        issue(4'b0001, got);
        chk("t2_grant", got, 0);
        @(negedge clk);
        chk("t2_add_valid", longint'(rsp_valid), 0);
        chk("t2_add_busy", longint'(busy), 1);
        @(negedge clk);
        chk("t2_resp_valid", longint'(rsp_valid), 1);
        chk("t2_sum", longint'($signed(rsp_sum)), 12252);
        drain();

        // T3 all valid, grants rotate
        apply_reset(1);
        set_all(-20785, -6903);
        for (int i = 0; i < 5; i++) begin
            issue(4'hF, got);
            chk("t3_grant", got, i % N);
        end
        drain();

        // T4 backpressure
        set_all(20025, -11168);
        rdy_mode = 2;
        issue(4'b0010, got);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_hold_valid", longint'(rsp_valid), 1);
            chk("t4_hold_sum", longint'($signed(rsp_sum)), 8857);
            req_valid = 4'hF;
            #1;
            chk("t4_req_ready", longint'(req_ready), 0);
            req_valid = '0;
        end
        rdy_mode = 0;
        @(negedge clk);
        chk("t4_ready_seen", longint'(rsp_ready), 1);
        @(negedge clk);
        chk("t4_done", longint'(busy), 0);
        chk("t4_valid_low", longint'(rsp_valid), 0);

        // T5 extremes
        set_all(-32768, -32768);
        issue(N'(1 << $urandom_range(0, N - 1)), got);
        set_all(32767, 32767);
        issue(N'(1 << $urandom_range(0, N - 1)), got);
        set_all(-30974, 26651);
        issue(N'(1 << $urandom_range(0, N - 1)), got);
        drain();

        // T6 reset during ADD
        apply_reset(1);
        set_all(100, 200);
        issue(4'b0100, got);
        chk("t6_grant", got, 2);
        apply_reset(1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t6_no_rsp", longint'(rsp_valid), 0);
        end
        issue(4'hF, got);
        chk("t6_after", got, 0);
        drain();

        // Randomized traffic with random backpressure
        rdy_mode = 1;
        for (int t = 0; t < 300; t++) begin
            for (int i = 0; i < N; i++) begin
                oa[i] = int'($urandom_range(0, 65535)) - 32768;
                ob[i] = int'($urandom_range(0, 65535)) - 32768;
            end
            mask = int'($urandom % 16);
            issue(N'(mask), got);
        end
        rdy_mode = 0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
